// File: rtl/hs_master_iterator_pkg.sv
// Shared definitions for the sync/ack handshake stages: FSM states and the
// {ack,sync} phase encoding seen from the master side of a 4-phase link.
package hs_master_iterator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef logic [1:0] hs_phase_t;

  // Phase = {ack, sync}; a full transaction walks IDLE -> REQ -> ACKED -> REL -> IDLE.
  localparam hs_phase_t PH_IDLE  = 2'b00;
  localparam hs_phase_t PH_REQ   = 2'b01;
  localparam hs_phase_t PH_ACKED = 2'b11;
  localparam hs_phase_t PH_REL   = 2'b10;

  function automatic hs_phase_t hs_phase(input logic ack, input logic sync);
    return {ack, sync};
  endfunction

endpackage

// File: rtl/hs_master_iterator_watchdog.sv
// Per-phase watchdog: counts cycles while enabled, flags expiry once the
// count reaches TIMEOUT_CYCLES-1; clear restarts the count.
module hs_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign expired = enable && (cnt_reg == LIMIT);

  // Saturates at LIMIT so a stalled owner never sees the count wrap.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (enable && !expired) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hs_master_iterator.sv
// Handshake master that iterates one sync/ack slave N times, feeding each
// slave result back as the next operand, with a watchdog on every ack phase.
module hs_master_iterator
  import hs_master_iterator_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] n_iter,
  input  logic [DATA_WIDTH-1:0]  seed,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [DATA_WIDTH-1:0]  result,
  output logic [COUNT_WIDTH-1:0] iter_cnt,
  output logic                   sync,
  output logic [DATA_WIDTH-1:0]  slv_data_in,
  input  logic                   ack,
  input  logic [DATA_WIDTH-1:0]  slv_data_out
);

  state_t                 state_reg;
  logic                   sync_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   error_reg;
  logic [DATA_WIDTH-1:0]  result_reg;
  logic [DATA_WIDTH-1:0]  slv_data_in_reg;
  logic [COUNT_WIDTH-1:0] iter_cnt_reg;
  logic [COUNT_WIDTH-1:0] n_iter_reg;

  hs_phase_t              phase;
  logic                   waiting;
  logic                   wd_expired;
  logic [COUNT_WIDTH-1:0] iter_cnt_inc;

  // Waiting means the state's awaited ack level has not shown up yet.
  always_comb begin
    phase   = hs_phase(ack, sync_reg);
    waiting = ((state_reg == ST_REQ) && (phase == PH_REQ)) ||
              ((state_reg == ST_REL) && (phase == PH_REL));
  end

  assign iter_cnt_inc = iter_cnt_reg + COUNT_WIDTH'(1);

  // Any cycle not spent waiting re-arms the watchdog for the next phase.
  hs_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (!waiting),
    .enable (waiting),
    .expired(wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      sync_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      result_reg      <= '0;
      slv_data_in_reg <= '0;
      iter_cnt_reg    <= '0;
      n_iter_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_ERROR: begin
          // A start is only taken once the slave has released ack.
          if (start && (phase == PH_IDLE)) begin
            n_iter_reg      <= n_iter;
            slv_data_in_reg <= seed;
            iter_cnt_reg    <= '0;
            error_reg       <= 1'b0;
            busy_reg        <= 1'b1;
            if (n_iter != '0) begin
              sync_reg  <= 1'b1;
              state_reg <= ST_REQ;
            end else begin
              result_reg <= seed;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          if (phase == PH_ACKED) begin
            slv_data_in_reg <= slv_data_out;
            sync_reg        <= 1'b0;
            state_reg       <= ST_REL;
          end else if (wd_expired) begin
            sync_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= ST_ERROR;
          end
        end
        ST_REL: begin
          if (phase == PH_IDLE) begin
            iter_cnt_reg <= iter_cnt_inc;
            if (iter_cnt_inc == n_iter_reg) begin
              result_reg <= slv_data_in_reg;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end else begin
              sync_reg  <= 1'b1;
              state_reg <= ST_REQ;
            end
          end else if (wd_expired) begin
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= ST_ERROR;
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign error       = error_reg;
  assign result      = result_reg;
  assign iter_cnt    = iter_cnt_reg;
  assign sync        = sync_reg;
  assign slv_data_in = slv_data_in_reg;

endmodule
